// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: converts single-word core read/write requests into an
// asynchronous-SRAM style access (SETUP, STROBE, HOLD) with optional
// wait-state extension and timeout. Every output is driven from a flop.
`timescale 1ns/1ps
module mem_bus_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned MAX_WAIT    = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic [15:0] i_address,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_ready,
    output logic        o_err,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    output logic        o_mem_cs_n,
    output logic        o_mem_oe_n,
    output logic        o_mem_we_n,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_wait
);

    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);
    localparam logic [7:0] LP_MAX  = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_timeout;
    logic        w_strobe_last;

    logic        r_is_rd;
    logic [3:0]  r_cnt;
    logic [7:0]  r_wcnt;
    logic [15:0] r_rdata;
    logic        r_ready;
    logic        r_err;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_mem_cs_n;
    logic        r_mem_oe_n;
    logic        r_mem_we_n;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic; the strobe's last base cycle is where i_mem_wait counts
    always_comb begin
        w_next        = r_state;
        w_timeout     = 1'b0;
        w_strobe_last = (r_cnt == 4'd0);
        case (r_state)
            IDLE:   if (i_rd ^ i_wr) w_next = SETUP;
            SETUP:  w_next = STROBE;
            STROBE: begin
                if (w_strobe_last) begin
                    if (i_mem_wait && (r_wcnt != LP_MAX)) begin
                        w_next = STROBE;
                    end else begin
                        w_next    = HOLD;
                        w_timeout = i_mem_wait;
                    end
                end
            end
            HOLD:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath and bus pins, registered one cycle ahead of the state they belong to
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_is_rd     <= 1'b0;
            r_cnt       <= 4'd0;
            r_wcnt      <= 8'd0;
            r_rdata     <= 16'd0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_mem_addr  <= 16'd0;
            r_mem_wdata <= 16'd0;
            r_mem_cs_n  <= 1'b1;
            r_mem_oe_n  <= 1'b1;
            r_mem_we_n  <= 1'b1;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_rd && i_wr) begin
                        r_err <= 1'b1;
                    end else if (i_rd || i_wr) begin
                        r_is_rd     <= i_rd;
                        r_mem_addr  <= i_address;
                        r_mem_wdata <= i_wdata;
                        r_mem_cs_n  <= 1'b0;
                    end
                end
                SETUP: begin
                    r_cnt      <= LP_WAIT;
                    r_wcnt     <= 8'd0;
                    r_mem_oe_n <= ~r_is_rd;
                    r_mem_we_n <= r_is_rd;
                end
                STROBE: begin
                    if (!w_strobe_last) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (w_next == STROBE) begin
                        r_wcnt <= r_wcnt + 8'd1;
                    end else begin
                        r_mem_oe_n <= 1'b1;
                        r_mem_we_n <= 1'b1;
                        r_ready    <= 1'b1;
                        r_err      <= w_timeout;
                        r_wcnt     <= 8'd0;
                        if (r_is_rd) r_rdata <= w_timeout ? 16'hFFFF : i_mem_rdata;
                    end
                end
                HOLD: begin
                    r_mem_cs_n <= 1'b1;
                end
                default: begin
                    r_mem_cs_n <= 1'b1;
                end
            endcase
        end
    end

    assign o_rdata     = r_rdata;
    assign o_ready     = r_ready;
    assign o_err       = r_err;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_cs_n  = r_mem_cs_n;
    assign o_mem_oe_n  = r_mem_oe_n;
    assign o_mem_we_n  = r_mem_we_n;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a scoreboard of expected completions.
`timescale 1ns/1ps
module tb_mem_bus_ctrl;

    localparam int WC = 1;
    localparam int MW = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_rd = 1'b0;
    logic        i_wr = 1'b0;
    logic [15:0] i_address = 16'd0;
    logic [15:0] i_wdata = 16'd0;
    logic [15:0] o_rdata;
    logic        o_ready;
    logic        o_err;
    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic        o_mem_cs_n;
    logic        o_mem_oe_n;
    logic        o_mem_we_n;
    logic [15:0] i_mem_rdata = 16'd0;
    logic        i_mem_wait = 1'b0;

    int passes = 0;
    int fails  = 0;
    int checks = 0;
    logic [16:0] sb_q[$];
    logic [15:0] model_rdata = 16'd0;

    mem_bus_ctrl #(.WAIT_CYCLES(WC), .MAX_WAIT(MW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rd(i_rd), .i_wr(i_wr),
        .i_address(i_address), .i_wdata(i_wdata), .o_rdata(o_rdata),
        .o_ready(o_ready), .o_err(o_err), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_cs_n(o_mem_cs_n),
        .o_mem_oe_n(o_mem_oe_n), .o_mem_we_n(o_mem_we_n),
        .i_mem_rdata(i_mem_rdata), .i_mem_wait(i_mem_wait)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One complete access; cycle 1 is the first cycle after the request is sampled
    task automatic access(input logic rd, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] rbase, input bit vary, input int wait_n,
                          input string tag);
        int ext, strobe, cyc, strobe_seen, bad, ready_cyc;
        bit tmo;
        logic [15:0] exp_rd;
        logic [16:0] exp;
        tmo    = (wait_n > MW);
        ext    = tmo ? MW : wait_n;
        strobe = WC + 1 + ext;
        if (rd) exp_rd = tmo ? 16'hFFFF : (vary ? rbase + 16'(1 + strobe) : rbase);
        else    exp_rd = model_rdata;
        model_rdata = exp_rd;
        sb_q.push_back({tmo, exp_rd});

        i_rd = rd; i_wr = ~rd; i_address = addr; i_wdata = wdata;
        i_mem_rdata = rbase; i_mem_wait = 1'b0;
        tick();
        // Garbage on the request side while busy must be ignored
        i_rd = 1'b1; i_wr = 1'b1; i_address = ~addr; i_wdata = ~wdata;
        cyc = 1; strobe_seen = 0; bad = 0; ready_cyc = 0;
        while (cyc < 300) begin
            i_mem_wait  = (cyc >= WC + 2) && (cyc < WC + 2 + wait_n);
            i_mem_rdata = vary ? rbase + 16'(cyc) : rbase;
            if (!o_mem_oe_n || !o_mem_we_n) strobe_seen++;
            if (!o_mem_oe_n && !o_mem_we_n) bad++;
            if (rd ? !o_mem_we_n : !o_mem_oe_n) bad++;
            if (o_mem_cs_n) bad++;
            if (o_err && !o_ready) bad++;
            if (o_ready) begin
                ready_cyc = cyc;
                break;
            end
            tick();
            cyc++;
        end
        i_rd = 1'b0; i_wr = 1'b0; i_mem_wait = 1'b0;
        chk({tag, "_ready_cycle"}, ready_cyc, strobe + 2);
        chk({tag, "_strobe_len"}, strobe_seen, strobe);
        chk({tag, "_bus_hygiene"}, bad, 0);
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            chk({tag, "_rdata"}, o_rdata, exp[15:0]);
            chk({tag, "_err"}, o_err, exp[16]);
        end else begin
            chk({tag, "_sb_empty"}, 1, 0);
        end
        chk({tag, "_mem_addr"}, o_mem_addr, addr);
        if (!rd) chk({tag, "_mem_wdata"}, o_mem_wdata, wdata);
        tick();
        chk({tag, "_idle_ctrl"}, {o_ready, o_err, o_mem_cs_n, o_mem_oe_n, o_mem_we_n}, 5'b00111);
        chk({tag, "_idle_addr"}, o_mem_addr, addr);
    endtask

    initial begin
        #1 i_rst_n = 1'b0;
        #1;
        chk("reset_ctrl", {o_ready, o_err, o_mem_cs_n, o_mem_oe_n, o_mem_we_n}, 5'b00111);
        chk("reset_data", {o_rdata, o_mem_addr, o_mem_wdata}, 48'd0);
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();

        access(1'b1, 16'h1234, 16'h0000, 16'hBEEF, 1'b0, 0,   "rd_basic");
        access(1'b0, 16'h00FF, 16'hA5A5, 16'h7777, 1'b0, 0,   "wr_basic");
        access(1'b1, 16'h2468, 16'h0000, 16'h1000, 1'b1, 3,   "rd_wait3");
        access(1'b1, 16'h0042, 16'h0000, 16'h3333, 1'b0, 100, "rd_timeout");
        access(1'b1, 16'h0043, 16'h0000, 16'h5000, 1'b1, MW,  "rd_wait_max");

        // Read and write together: one error pulse, no access
        i_rd = 1'b1; i_wr = 1'b1; i_address = 16'h9999;
        tick();
        chk("conflict_pulse", {o_err, o_ready, o_mem_cs_n}, 3'b101);
        i_rd = 1'b0; i_wr = 1'b0;
        tick();
        chk("conflict_after", {o_err, o_ready, o_mem_cs_n}, 3'b001);

        // Reset during the strobe of a write
        i_wr = 1'b1; i_address = 16'h5555; i_wdata = 16'h1111;
        tick();
        tick();
        chk("abort_we_low", {o_mem_cs_n, o_mem_we_n}, 2'b00);
        i_wr = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        chk("abort_async", {o_mem_cs_n, o_mem_we_n, o_mem_oe_n, o_ready}, 4'b1110);
        chk("abort_rdata", o_rdata, 16'h0000);
        model_rdata = 16'h0000;
        tick();
        i_rst_n = 1'b1;
        begin
            int seen_ready;
            seen_ready = 0;
            for (int k = 0; k < 8; k++) begin
                tick();
                if (o_ready || !o_mem_cs_n) seen_ready++;
            end
            chk("abort_no_completion", seen_ready, 0);
        end

        access(1'b1, 16'h4321, 16'h0000, 16'h0BAD, 1'b0, 0, "rd_after_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
